// File: rtl/ibexc_rvfi_trace_fifo.sv
// RVFI retirement trace FIFO: captures one record per retired instruction and
// drains each record as a 4-beat 32-bit packet over a valid/ready trace port.
module ibexc_rvfi_trace_fifo #(
  parameter int Depth    = 8,
  parameter int DropCntW = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       trace_en_i,
  input  logic                       rvfi_valid,
  input  logic [63:0]                rvfi_order,
  input  logic [31:0]                rvfi_insn,
  input  logic                       rvfi_trap,
  input  logic                       rvfi_intr,
  input  logic [1:0]                 rvfi_mode,
  input  logic [4:0]                 rvfi_rd_addr,
  input  logic [31:0]                rvfi_rd_wdata,
  input  logic [31:0]                rvfi_pc_rdata,
  output logic                       trace_valid_o,
  output logic [31:0]                trace_data_o,
  output logic                       trace_last_o,
  input  logic                       trace_ready_i,
  output logic [$clog2(Depth):0]     fifo_level_o,
  output logic [DropCntW-1:0]        drop_cnt_o,
  output logic                       busy_o
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic        drop;
    logic [14:0] order;
    logic        trap;
    logic        intr;
    logic [1:0]  mode;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc;
    logic [31:0] insn;
  } rec_t;

  typedef enum logic [1:0] {BEAT0, BEAT1, BEAT2, BEAT3} beat_e;

  rec_t                mem [Depth];
  rec_t                head;
  rec_t                new_rec;
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic                busy_q;
  beat_e               beat_q, beat_d;
  logic                drop_pending_q;
  logic [DropCntW-1:0] drop_cnt_q;

  logic full, handshake, pop, capture, push, drop;

  // Only the low order bits travel in the packet.
  logic unused_order;
  assign unused_order = ^rvfi_order[63:15];

  assign full      = (level_q == LW'(Depth));
  assign handshake = busy_q && trace_ready_i;
  assign pop       = handshake && (beat_q == BEAT3);
  assign capture   = rvfi_valid && trace_en_i;
  assign push      = capture && (!full || pop);
  assign drop      = capture && full && !pop;

  assign new_rec = '{drop:     drop_pending_q,
                     order:    rvfi_order[14:0],
                     trap:     rvfi_trap,
                     intr:     rvfi_intr,
                     mode:     rvfi_mode,
                     rd_addr:  rvfi_rd_addr,
                     rd_wdata: rvfi_rd_wdata,
                     pc:       rvfi_pc_rdata,
                     insn:     rvfi_insn};

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset; occupancy is tracked solely by the pointers and level.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr_q] <= new_rec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      level_q        <= '0;
      busy_q         <= 1'b0;
      drop_pending_q <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      busy_q  <= (level_d != '0);
      if (push) begin
        drop_pending_q <= 1'b0;
      end else if (drop) begin
        drop_pending_q <= 1'b1;
      end
      if (drop && !(&drop_cnt_q)) begin
        drop_cnt_q <= drop_cnt_q + DropCntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= BEAT0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign head = mem[rptr_q];

  always_comb begin
    beat_d       = beat_q;
    trace_data_o = '0;
    trace_last_o = 1'b0;
    if (handshake) begin
      unique case (beat_q)
        BEAT0:   beat_d = BEAT1;
        BEAT1:   beat_d = BEAT2;
        BEAT2:   beat_d = BEAT3;
        default: beat_d = BEAT0;
      endcase
    end
    if (busy_q) begin
      unique case (beat_q)
        BEAT0: trace_data_o = {(head.drop ? 8'hD5 : 8'hA5), head.order, head.trap,
                               head.intr, head.mode, head.rd_addr};
        BEAT1: trace_data_o = head.pc;
        BEAT2: trace_data_o = head.insn;
        default: begin
          trace_data_o = head.rd_wdata;
          trace_last_o = 1'b1;
        end
      endcase
    end
  end

  assign trace_valid_o = busy_q;
  assign busy_o        = busy_q;
  assign fifo_level_o  = level_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_ibexc_rvfi_trace_fifo.sv
// Self-checking bench for ibexc_rvfi_trace_fifo: table-driven vectors plus
// hand-written multi-cycle sequences for overflow, backpressure and reset.
module tb_ibexc_rvfi_trace_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trace_en_i;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic        rvfi_intr;
  logic [1:0]  rvfi_mode;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata;
  logic        trace_valid_o;
  logic [31:0] trace_data_o;
  logic        trace_last_o;
  logic        trace_ready_i;
  logic [3:0]  fifo_level_o;
  logic [15:0] drop_cnt_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  ibexc_rvfi_trace_fifo #(.Depth(8), .DropCntW(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .trace_en_i    (trace_en_i),
    .rvfi_valid    (rvfi_valid),
    .rvfi_order    (rvfi_order),
    .rvfi_insn     (rvfi_insn),
    .rvfi_trap     (rvfi_trap),
    .rvfi_intr     (rvfi_intr),
    .rvfi_mode     (rvfi_mode),
    .rvfi_rd_addr  (rvfi_rd_addr),
    .rvfi_rd_wdata (rvfi_rd_wdata),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .trace_valid_o (trace_valid_o),
    .trace_data_o  (trace_data_o),
    .trace_last_o  (trace_last_o),
    .trace_ready_i (trace_ready_i),
    .fifo_level_o  (fifo_level_o),
    .drop_cnt_o    (drop_cnt_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v, en, rdy;
    logic [14:0] ord;
    logic [31:0] pc, insn, wd;
    logic [4:0]  rd;
    logic        tr, it;
    logic [1:0]  md;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [3:0]  elev;
    logic [15:0] edrop;
  } vec_t;

  vec_t vecs[10];

  // Inputs change and outputs are sampled mid-cycle, one time unit after the falling edge.
  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic en, input logic rdy,
                               input logic [14:0] ord, input logic [31:0] pc,
                               input logic [31:0] insn, input logic [31:0] wd,
                               input logic [4:0] rd, input logic tr, input logic it,
                               input logic [1:0] md);
    rvfi_valid    = v;
    trace_en_i    = en;
    trace_ready_i = rdy;
    rvfi_order    = {49'h1_2345_6789_ABCD, ord};
    rvfi_pc_rdata = pc;
    rvfi_insn     = insn;
    rvfi_rd_wdata = wd;
    rvfi_rd_addr  = rd;
    rvfi_trap     = tr;
    rvfi_intr     = it;
    rvfi_mode     = md;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Record i of the generated sequences.
  function automatic logic [31:0] recPc(int i);   return 32'h1000_0000 + 32'(i) * 4; endfunction
  function automatic logic [31:0] recInsn(int i); return 32'h0100_0000 + 32'(i); endfunction
  function automatic logic [31:0] recWd(int i);   return 32'hCAFE_0000 + 32'(i); endfunction

  function automatic logic [31:0] recBeat(int i, int b, logic drop);
    logic [31:0] r;
    logic [31:0] ii;
    ii = 32'(i);
    case (b)
      0:       r = {(drop ? 8'hD5 : 8'hA5), ii[14:0], ii[0], ii[1], ii[3:2], ii[4:0]};
      1:       r = recPc(i);
      2:       r = recInsn(i);
      default: r = recWd(i);
    endcase
    return r;
  endfunction

  task automatic driveRec(int i, logic v, logic en, logic rdy);
    logic [31:0] ii;
    ii = 32'(i);
    applyStimulus(v, en, rdy, ii[14:0], recPc(i), recInsn(i), recWd(i), ii[4:0],
                  ii[0], ii[1], ii[3:2]);
  endtask

  task automatic idle(logic en, logic rdy);
    applyStimulus(1'b0, en, rdy, 15'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic doReset();
    idle(1'b1, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle(1'b1, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;

    checkOutput("reset_valid", 32'(trace_valid_o), 32'd0);
    checkOutput("reset_data",  trace_data_o, 32'd0);
    checkOutput("reset_last",  32'(trace_last_o), 32'd0);
    checkOutput("reset_level", 32'(fifo_level_o), 32'd0);
    checkOutput("reset_drop",  32'(drop_cnt_o), 32'd0);
    checkOutput("reset_busy",  32'(busy_o), 32'd0);

    // Single retire followed by capture-disabled retires on an empty FIFO.
    vecs[0] = '{1,1,1, 15'd5, 32'h8000_0000, 32'h0010_0093, 32'h1, 5'd1, 0,0, 2'd0,
                0, 32'h0, 0, 4'd0, 16'd0};
    vecs[1] = '{0,1,1, 15'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0, 2'd0,
                1, 32'hA500_0A01, 0, 4'd1, 16'd0};
    vecs[2] = '{0,1,1, 15'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0, 2'd0,
                1, 32'h8000_0000, 0, 4'd1, 16'd0};
    vecs[3] = '{0,1,1, 15'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0, 2'd0,
                1, 32'h0010_0093, 0, 4'd1, 16'd0};
    vecs[4] = '{0,1,1, 15'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0, 2'd0,
                1, 32'h0000_0001, 1, 4'd1, 16'd0};
    vecs[5] = '{0,1,1, 15'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0, 2'd0,
                0, 32'h0, 0, 4'd0, 16'd0};
    vecs[6] = '{1,0,1, 15'd5, 32'h8000_0000, 32'h0010_0093, 32'h1, 5'd1, 0,0, 2'd0,
                0, 32'h0, 0, 4'd0, 16'd0};
    vecs[7] = '{1,0,1, 15'd6, 32'h8000_0004, 32'h0020_0113, 32'h2, 5'd2, 1,1, 2'd3,
                0, 32'h0, 0, 4'd0, 16'd0};
    vecs[8] = '{1,0,0, 15'd7, 32'h8000_0008, 32'h0030_0193, 32'h3, 5'd3, 0,0, 2'd1,
                0, 32'h0, 0, 4'd0, 16'd0};
    vecs[9] = '{0,1,1, 15'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0, 2'd0,
                0, 32'h0, 0, 4'd0, 16'd0};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].v, vecs[i].en, vecs[i].rdy, vecs[i].ord, vecs[i].pc,
                    vecs[i].insn, vecs[i].wd, vecs[i].rd, vecs[i].tr, vecs[i].it, vecs[i].md);
      checkOutput($sformatf("vec%0d_valid", i), 32'(trace_valid_o), 32'(vecs[i].ev));
      checkOutput($sformatf("vec%0d_data", i),  trace_data_o, vecs[i].ed);
      checkOutput($sformatf("vec%0d_last", i),  32'(trace_last_o), 32'(vecs[i].el));
      checkOutput($sformatf("vec%0d_level", i), 32'(fifo_level_o), 32'(vecs[i].elev));
      checkOutput($sformatf("vec%0d_drop", i),  32'(drop_cnt_o), 32'(vecs[i].edrop));
      tick();
    end

    // Overflow: 10 retires into a stalled FIFO, then drain with an 11th record pushed.
    doReset();
    for (int i = 0; i < 10; i++) begin
      driveRec(i, 1'b1, 1'b1, 1'b0);
      tick();
    end
    idle(1'b1, 1'b0);
    checkOutput("ovf_level", 32'(fifo_level_o), 32'd8);
    checkOutput("ovf_drop",  32'(drop_cnt_o), 32'd2);
    checkOutput("ovf_hold",  trace_data_o, recBeat(0, 0, 1'b0));
    tick();
    checkOutput("ovf_hold2", trace_data_o, recBeat(0, 0, 1'b0));
    for (int p = 0; p < 9; p++) begin
      for (int b = 0; b < 4; b++) begin
        if (p == 1 && b == 0) begin
          checkOutput("ovf_level_after_pop", 32'(fifo_level_o), 32'd7);
          driveRec(10, 1'b1, 1'b1, 1'b1);
        end else begin
          idle(1'b1, 1'b1);
        end
        checkOutput($sformatf("ovf_p%0d_b%0d", p, b), trace_data_o,
                    recBeat((p == 8) ? 10 : p, b, p == 8));
        checkOutput($sformatf("ovf_p%0d_b%0d_last", p, b), 32'(trace_last_o),
                    32'(b == 3));
        tick();
      end
    end
    idle(1'b1, 1'b1);
    checkOutput("ovf_empty_valid", 32'(trace_valid_o), 32'd0);
    checkOutput("ovf_empty_level", 32'(fifo_level_o), 32'd0);
    checkOutput("ovf_final_drop",  32'(drop_cnt_o), 32'd2);

    // Backpressure: ready toggles every cycle; the packet takes 8 cycles.
    doReset();
    driveRec(3, 1'b1, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 8; c++) begin
      idle(1'b1, 1'(c % 2));
      checkOutput($sformatf("bp_c%0d_data", c), trace_data_o, recBeat(3, c / 2, 1'b0));
      checkOutput($sformatf("bp_c%0d_last", c), 32'(trace_last_o), 32'(c / 2 == 3));
      tick();
    end
    idle(1'b1, 1'b0);
    checkOutput("bp_done_valid", 32'(trace_valid_o), 32'd0);
    checkOutput("bp_done_level", 32'(fifo_level_o), 32'd0);

    // Full FIFO with a push coinciding with the BEAT3 handshake.
    doReset();
    for (int i = 0; i < 8; i++) begin
      driveRec(i, 1'b1, 1'b1, 1'b0);
      tick();
    end
    for (int b = 0; b < 3; b++) begin
      idle(1'b1, 1'b1);
      tick();
    end
    driveRec(20, 1'b1, 1'b1, 1'b1);
    checkOutput("fpp_beat3", trace_data_o, recWd(0));
    checkOutput("fpp_last",  32'(trace_last_o), 32'd1);
    tick();
    idle(1'b1, 1'b1);
    checkOutput("fpp_level", 32'(fifo_level_o), 32'd8);
    checkOutput("fpp_drop",  32'(drop_cnt_o), 32'd0);
    for (int c = 0; c < 28; c++) tick();
    checkOutput("fpp_new_beat0", trace_data_o, recBeat(20, 0, 1'b0));
    tick();
    checkOutput("fpp_new_beat1", trace_data_o, recPc(20));
    for (int c = 0; c < 3; c++) tick();
    checkOutput("fpp_drained", 32'(fifo_level_o), 32'd0);

    // Reset during BEAT2 with a drop marker pending.
    doReset();
    for (int i = 0; i < 9; i++) begin
      driveRec(i, 1'b1, 1'b1, 1'b0);
      tick();
    end
    idle(1'b1, 1'b1);
    tick();
    tick();
    checkOutput("rst_at_beat2", trace_data_o, recInsn(0));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("rst_valid", 32'(trace_valid_o), 32'd0);
    checkOutput("rst_level", 32'(fifo_level_o), 32'd0);
    checkOutput("rst_drop",  32'(drop_cnt_o), 32'd0);
    driveRec(9, 1'b1, 1'b1, 1'b1);
    tick();
    idle(1'b1, 1'b1);
    checkOutput("rst_new_beat0", trace_data_o, recBeat(9, 0, 1'b0));

    // Capture disabled while entries are queued: the queue still drains.
    doReset();
    driveRec(1, 1'b1, 1'b1, 1'b0);
    tick();
    driveRec(2, 1'b1, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 8; c++) begin
      driveRec(30 + c, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("dis_c%0d_data", c), trace_data_o,
                  recBeat(1 + c / 4, c % 4, 1'b0));
      tick();
    end
    idle(1'b0, 1'b1);
    checkOutput("dis_valid", 32'(trace_valid_o), 32'd0);
    checkOutput("dis_level", 32'(fifo_level_o), 32'd0);
    checkOutput("dis_drop",  32'(drop_cnt_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
